// File: rtl/jtag_tap_controller.sv
// JTAG TAP controller: IEEE 1149.1 TAP state machine, instruction register,
// BYPASS and IDCODE data registers, and boundary-scan control strobes.
module jtag_tap_controller #(
    parameter int unsigned IR_WIDTH = 4,
    parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
    input  logic TCK,
    input  logic TRST_n,
    input  logic TMS,
    input  logic TDI,
    input  logic bsr_tdo,
    output logic ShiftDR,
    output logic ClockDR,
    output logic UpdateDR,
    output logic Mode,
    output logic TDO,
    output logic TDO_en
);

    typedef enum logic [3:0] {
        StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPaDr, StEx2Dr, StUpdDr,
        StSelIr, StCapIr, StShIr, StEx1Ir, StPaIr, StEx2Ir, StUpdIr
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] IrCapture   = IR_WIDTH'(4'b0101);
    localparam logic [IR_WIDTH-1:0] InstrExtest = IR_WIDTH'(4'b0000);
    localparam logic [IR_WIDTH-1:0] InstrSample = IR_WIDTH'(4'b0010);
    localparam logic [IR_WIDTH-1:0] InstrIdcode = IR_WIDTH'(4'b0001);

    tap_state_e          state_q;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic                bypass_q;
    logic [31:0]         id_q;
    logic                clkdr_en_q;
    logic                sel_bsr;
    logic                sel_id;
    logic                dr_clk_window;
    logic                tdo_d;
    logic                tdo_en_d;

    // TAP state machine, advanced by TMS on the rising edge of TCK
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            state_q <= StTlr;
        end else begin
            case (state_q)
                StTlr:   state_q <= TMS ? StTlr   : StRti;
                StRti:   state_q <= TMS ? StSelDr : StRti;
                StSelDr: state_q <= TMS ? StSelIr : StCapDr;
                StCapDr: state_q <= TMS ? StEx1Dr : StShDr;
                StShDr:  state_q <= TMS ? StEx1Dr : StShDr;
                StEx1Dr: state_q <= TMS ? StUpdDr : StPaDr;
                StPaDr:  state_q <= TMS ? StEx2Dr : StPaDr;
                StEx2Dr: state_q <= TMS ? StUpdDr : StShDr;
                StUpdDr: state_q <= TMS ? StSelDr : StRti;
                StSelIr: state_q <= TMS ? StTlr   : StCapIr;
                StCapIr: state_q <= TMS ? StEx1Ir : StShIr;
                StShIr:  state_q <= TMS ? StEx1Ir : StShIr;
                StEx1Ir: state_q <= TMS ? StUpdIr : StPaIr;
                StPaIr:  state_q <= TMS ? StEx2Ir : StPaIr;
                StEx2Ir: state_q <= TMS ? StUpdIr : StShIr;
                StUpdIr: state_q <= TMS ? StSelDr : StRti;
                default: state_q <= StTlr;
            endcase
        end
    end

    // Instruction shift register: capture 0101, then shift LSB-first from TDI
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_shift_q <= IrCapture;
        end else if (state_q == StTlr || state_q == StCapIr) begin
            ir_shift_q <= IrCapture;
        end else if (state_q == StShIr) begin
            ir_shift_q <= {TDI, ir_shift_q[IR_WIDTH-1:1]};
        end
    end

    // Active instruction, updated while TCK is low so decode never changes mid-DR-scan
    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_q <= InstrIdcode;
        end else if (state_q == StTlr) begin
            ir_q <= InstrIdcode;
        end else if (state_q == StUpdIr) begin
            ir_q <= ir_shift_q;
        end
    end

    // Instruction decode; unrecognised codes fall through to BYPASS
    always_comb begin
        sel_bsr       = (ir_q == InstrExtest) || (ir_q == InstrSample);
        sel_id        = (ir_q == InstrIdcode);
        dr_clk_window = sel_bsr && ((state_q == StCapDr) || (state_q == StShDr));
    end

    // BYPASS and IDCODE registers: capture, then shift the selected one toward TDO
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            bypass_q <= 1'b0;
            id_q     <= IDCODE;
        end else if (state_q == StCapDr) begin
            bypass_q <= 1'b0;
            id_q     <= IDCODE;
        end else if (state_q == StShDr) begin
            if (sel_id) begin
                id_q <= {TDI, id_q[31:1]};
            end else if (!sel_bsr) begin
                bypass_q <= TDI;
            end
        end
    end

    // Serial output selection for the current state
    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state_q == StShIr) begin
            tdo_en_d = 1'b1;
            tdo_d    = ir_shift_q[0];
        end else if (state_q == StShDr) begin
            tdo_en_d = 1'b1;
            if (sel_bsr) begin
                tdo_d = bsr_tdo;
            end else if (sel_id) begin
                tdo_d = id_q[0];
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    // TDO and its enable change on the falling edge, half a cycle before the next sample
    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end else begin
            TDO    <= tdo_d;
            TDO_en <= tdo_en_d;
        end
    end

    // ClockDR gate enable, changed only while TCK is low
    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            clkdr_en_q <= 1'b0;
        end else begin
            clkdr_en_q <= dr_clk_window;
        end
    end

    // The window term keeps ClockDR high when the enable drops on the same falling edge
    assign ClockDR  = TCK | ~(clkdr_en_q & dr_clk_window);
    assign UpdateDR = ~TCK & (state_q == StUpdDr) & sel_bsr;
    assign ShiftDR  = (state_q == StShDr) && sel_bsr;
    assign Mode     = (ir_q == InstrExtest);

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller: directed scenarios plus a random
// TMS/TDI walk checked against a table-driven TAP model.
module tb_jtag_tap_controller;

    logic TCK;
    logic TRST_n;
    logic TMS;
    logic TDI;
    logic bsr_tdo;
    logic ShiftDR;
    logic ClockDR;
    logic UpdateDR;
    logic Mode;
    logic TDO;
    logic TDO_en;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          clk_rises = 0;
    int          upd_rises = 0;
    logic [31:0] idc_word = 32'h1000_0001;

    // Reference model state
    string       nxt0[string];
    string       nxt1[string];
    string       m_st;
    logic [3:0]  m_irsh;
    logic [3:0]  m_ir;
    bit          m_dr[$];
    bit          m_tdo;
    bit          m_tdo_en;

    jtag_tap_controller #(
        .IR_WIDTH(4),
        .IDCODE  (32'h1000_0001)
    ) dut (
        .TCK     (TCK),
        .TRST_n  (TRST_n),
        .TMS     (TMS),
        .TDI     (TDI),
        .bsr_tdo (bsr_tdo),
        .ShiftDR (ShiftDR),
        .ClockDR (ClockDR),
        .UpdateDR(UpdateDR),
        .Mode    (Mode),
        .TDO     (TDO),
        .TDO_en  (TDO_en)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    always @(posedge ClockDR) clk_rises++;
    always @(posedge UpdateDR) upd_rises++;

    function automatic void add_edge(string s, string n0, string n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endfunction

    function automatic void init_table();
        add_edge("TLR", "RTI", "TLR");
        add_edge("RTI", "RTI", "SEL_DR");
        add_edge("SEL_DR", "CAP_DR", "SEL_IR");
        add_edge("CAP_DR", "SH_DR", "EX1_DR");
        add_edge("SH_DR", "SH_DR", "EX1_DR");
        add_edge("EX1_DR", "PA_DR", "UPD_DR");
        add_edge("PA_DR", "PA_DR", "EX2_DR");
        add_edge("EX2_DR", "SH_DR", "UPD_DR");
        add_edge("UPD_DR", "RTI", "SEL_DR");
        add_edge("SEL_IR", "CAP_IR", "TLR");
        add_edge("CAP_IR", "SH_IR", "EX1_IR");
        add_edge("SH_IR", "SH_IR", "EX1_IR");
        add_edge("EX1_IR", "PA_IR", "UPD_IR");
        add_edge("PA_IR", "PA_IR", "EX2_IR");
        add_edge("EX2_IR", "SH_IR", "UPD_IR");
        add_edge("UPD_IR", "RTI", "SEL_DR");
    endfunction

    function automatic bit m_bsr();
        return (m_ir == 4'b0000) || (m_ir == 4'b0010);
    endfunction

    function automatic void m_reset();
        m_st     = "TLR";
        m_ir     = 4'b0001;
        m_irsh   = 4'b0101;
        m_tdo    = 1'b0;
        m_tdo_en = 1'b0;
        m_dr.delete();
    endfunction

    // Data register modelled as a bit queue: front bit is what TDO presents
    function automatic void m_posedge(bit tms, bit tdi);
        if (m_st == "CAP_IR") begin
            m_irsh = 4'b0101;
        end else if (m_st == "SH_IR") begin
            m_irsh = {tdi, m_irsh[3:1]};
        end else if (m_st == "CAP_DR") begin
            m_dr.delete();
            if (m_ir == 4'b0001) begin
                for (int i = 0; i < 32; i++) m_dr.push_back(idc_word[i]);
            end else begin
                m_dr.push_back(1'b0);
            end
        end else if (m_st == "SH_DR" && m_dr.size() > 0) begin
            void'(m_dr.pop_front());
            m_dr.push_back(tdi);
        end
        m_st = tms ? nxt1[m_st] : nxt0[m_st];
    endfunction

    function automatic void m_negedge();
        if (m_st == "UPD_IR") m_ir = m_irsh;
        if (m_st == "TLR") m_ir = 4'b0001;
        m_tdo_en = (m_st == "SH_IR") || (m_st == "SH_DR");
        m_tdo    = 1'b0;
        if (m_st == "SH_IR") begin
            m_tdo = m_irsh[0];
        end else if (m_st == "SH_DR") begin
            if (m_bsr()) m_tdo = bsr_tdo;
            else if (m_dr.size() > 0) m_tdo = m_dr[0];
        end
    endfunction

    // One TCK cycle: inputs applied while TCK is low, outputs settled after the falling edge
    task automatic clk(input bit tms, input bit tdi);
        TMS     = tms;
        TDI     = tdi;
        bsr_tdo = 1'($urandom_range(0, 1));
        @(posedge TCK);
        m_posedge(tms, tdi);
        @(negedge TCK);
        #1;
        m_negedge();
    endtask

    task automatic load_ir(input logic [3:0] v);
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) clk(i == 3, v[i]);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        TRST_n  = 1'b0;
        TMS     = 1'b1;
        TDI     = 1'b0;
        bsr_tdo = 1'b0;
        #12;
        n_vec++; if (TDO !== 1'b0) begin n_bad++; $display("FAIL reset_tdo: got %b want 0", TDO); end
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL reset_tdo_en: got %b want 0", TDO_en); end
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL reset_mode: got %b want 0", Mode); end
        n_vec++; if (ClockDR !== 1'b1) begin n_bad++; $display("FAIL reset_clockdr: got %b want 1", ClockDR); end
        n_vec++; if (UpdateDR !== 1'b0) begin n_bad++; $display("FAIL reset_updatedr: got %b want 0", UpdateDR); end
        n_vec++; if (ShiftDR !== 1'b0) begin n_bad++; $display("FAIL reset_shiftdr: got %b want 0", ShiftDR); end
        @(negedge TCK);
        #1;
        TRST_n = 1'b1;
        m_reset();
        repeat (5) clk(1'b1, 1'b0);
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL tlr_mode: got %b want 0", Mode); end
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL tlr_tdo_en: got %b want 0", TDO_en); end
        n_vec++; if (ClockDR !== 1'b1) begin n_bad++; $display("FAIL tlr_clockdr: got %b want 1", ClockDR); end
    endtask

    task automatic test_idcode();
        clk(1'b0, 1'b0);
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL idc_rti_en: got %b want 0", TDO_en); end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL idc_cap_en: got %b want 0", TDO_en); end
        clk(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (TDO !== idc_word[i]) begin
                n_bad++; $display("FAIL idc_bit%0d: got %b want %b", i, TDO, idc_word[i]);
            end
            n_vec++;
            if (TDO_en !== 1'b1) begin
                n_bad++; $display("FAIL idc_en%0d: got %b want 1", i, TDO_en);
            end
            clk(i == 31, 1'($urandom_range(0, 1)));
        end
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL idc_ex1_en: got %b want 0", TDO_en); end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic test_ir_capture();
        logic [3:0] cap;
        cap = 4'b0101;
        clk(1'b1, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL ir_cap_en: got %b want 0", TDO_en); end
        clk(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (TDO !== cap[i]) begin
                n_bad++; $display("FAIL ir_cap_bit%0d: got %b want %b", i, TDO, cap[i]);
            end
            n_vec++;
            if (TDO_en !== 1'b1) begin
                n_bad++; $display("FAIL ir_sh_en%0d: got %b want 1", i, TDO_en);
            end
            clk(i == 3, 1'b0);
        end
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL ir_ex1_mode: got %b want 0", Mode); end
        // Step into UPD_IR by hand to see Mode before and after the falling edge
        TMS = 1'b1;
        TDI = 1'b0;
        @(posedge TCK);
        m_posedge(1'b1, 1'b0);
        #1;
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL upd_ir_hi_mode: got %b want 0", Mode); end
        @(negedge TCK);
        #1;
        m_negedge();
        n_vec++; if (Mode !== 1'b1) begin n_bad++; $display("FAIL upd_ir_lo_mode: got %b want 1", Mode); end
        clk(1'b0, 1'b0);
    endtask

    task automatic test_extest();
        int shift_hi;
        shift_hi  = 0;
        clk_rises = 0;
        upd_rises = 0;
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (ShiftDR === 1'b1) shift_hi++;
            n_vec++;
            if (TDO !== bsr_tdo) begin
                n_bad++; $display("FAIL ext_tdo%0d: got %b want %b", i, TDO, bsr_tdo);
            end
            n_vec++;
            if (Mode !== 1'b1) begin
                n_bad++; $display("FAIL ext_mode%0d: got %b want 1", i, Mode);
            end
            clk(i == 5, 1'($urandom_range(0, 1)));
        end
        n_vec++; if (ShiftDR !== 1'b0) begin n_bad++; $display("FAIL ext_ex1_shiftdr: got %b want 0", ShiftDR); end
        clk(1'b1, 1'b0);
        n_vec++; if (UpdateDR !== 1'b1) begin n_bad++; $display("FAIL ext_updatedr: got %b want 1", UpdateDR); end
        clk(1'b0, 1'b0);
        n_vec++; if (clk_rises != 7) begin n_bad++; $display("FAIL ext_clockdr_edges: got %0d want 7", clk_rises); end
        n_vec++; if (shift_hi != 6) begin n_bad++; $display("FAIL ext_shiftdr_cycles: got %0d want 6", shift_hi); end
        n_vec++; if (upd_rises != 1) begin n_bad++; $display("FAIL ext_update_pulses: got %0d want 1", upd_rises); end
        n_vec++; if (Mode !== 1'b1) begin n_bad++; $display("FAIL ext_mode_after: got %b want 1", Mode); end
    endtask

    task automatic test_bypass();
        logic [8:0] pat;
        logic       want;
        pat = 9'h0A5;
        load_ir(4'b1111);
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL byp_mode: got %b want 0", Mode); end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            want = (i == 0) ? 1'b0 : pat[i-1];
            n_vec++;
            if (TDO !== want) begin
                n_bad++; $display("FAIL byp_bit%0d: got %b want %b", i, TDO, want);
            end
            n_vec++;
            if (ShiftDR !== 1'b0) begin
                n_bad++; $display("FAIL byp_shiftdr%0d: got %b want 0", i, ShiftDR);
            end
            clk(i == 8, pat[i]);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic test_tlr_from_any();
        for (int t = 0; t < 4; t++) begin
            load_ir(4'b0000);
            repeat ($urandom_range(1, 20)) clk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat (5) clk(1'b1, 1'b0);
            n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL tlr%0d_mode: got %b want 0", t, Mode); end
            n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL tlr%0d_en: got %b want 0", t, TDO_en); end
            n_vec++; if (ClockDR !== 1'b1) begin n_bad++; $display("FAIL tlr%0d_clockdr: got %b want 1", t, ClockDR); end
            clk(1'b0, 1'b0);
            clk(1'b1, 1'b0);
            clk(1'b0, 1'b0);
            clk(1'b0, 1'b0);
            n_vec++; if (TDO !== 1'b1) begin n_bad++; $display("FAIL tlr%0d_idc_bit0: got %b want 1", t, TDO); end
            clk(1'b1, 1'b0);
            clk(1'b1, 1'b0);
            clk(1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        bit exp_shdr;
        bit exp_upd;
        bit exp_clkdr;
        load_ir(4'b0010);
        for (int n = 0; n < 400; n++) begin
            clk($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
            exp_shdr  = (m_st == "SH_DR") && m_bsr();
            exp_upd   = (m_st == "UPD_DR") && m_bsr();
            exp_clkdr = !(((m_st == "CAP_DR") || (m_st == "SH_DR")) && m_bsr());
            n_vec++;
            if (TDO !== m_tdo) begin
                n_bad++; $display("FAIL rnd%0d_tdo (%s): got %b want %b", n, m_st, TDO, m_tdo);
            end
            n_vec++;
            if (TDO_en !== m_tdo_en) begin
                n_bad++; $display("FAIL rnd%0d_tdo_en (%s): got %b want %b", n, m_st, TDO_en, m_tdo_en);
            end
            n_vec++;
            if (Mode !== (m_ir == 4'b0000)) begin
                n_bad++; $display("FAIL rnd%0d_mode: got %b want %b", n, Mode, m_ir == 4'b0000);
            end
            n_vec++;
            if (ShiftDR !== exp_shdr) begin
                n_bad++; $display("FAIL rnd%0d_shiftdr: got %b want %b", n, ShiftDR, exp_shdr);
            end
            n_vec++;
            if (UpdateDR !== exp_upd) begin
                n_bad++; $display("FAIL rnd%0d_updatedr: got %b want %b", n, UpdateDR, exp_upd);
            end
            n_vec++;
            if (ClockDR !== exp_clkdr) begin
                n_bad++; $display("FAIL rnd%0d_clockdr: got %b want %b", n, ClockDR, exp_clkdr);
            end
        end
        repeat (5) clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_scan();
        load_ir(4'b0000);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b1);
        clk(1'b0, 1'b0);
        n_vec++; if (ShiftDR !== 1'b1) begin n_bad++; $display("FAIL mid_pre_shiftdr: got %b want 1", ShiftDR); end
        upd_rises = 0;
        TMS = 1'b1;
        @(posedge TCK);
        #2;
        TRST_n = 1'b0;
        #1;
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL mid_mode: got %b want 0", Mode); end
        n_vec++; if (ShiftDR !== 1'b0) begin n_bad++; $display("FAIL mid_shiftdr: got %b want 0", ShiftDR); end
        n_vec++; if (ClockDR !== 1'b1) begin n_bad++; $display("FAIL mid_clockdr: got %b want 1", ClockDR); end
        n_vec++; if (TDO_en !== 1'b0) begin n_bad++; $display("FAIL mid_tdo_en: got %b want 0", TDO_en); end
        repeat (3) @(negedge TCK);
        #1;
        TRST_n = 1'b1;
        m_reset();
        clk(1'b0, 1'b0);
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        clk(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (TDO !== idc_word[i]) begin
                n_bad++; $display("FAIL mid_idc_bit%0d: got %b want %b", i, TDO, idc_word[i]);
            end
            clk(i == 7, 1'b0);
        end
        clk(1'b1, 1'b0);
        clk(1'b0, 1'b0);
        n_vec++; if (upd_rises != 0) begin n_bad++; $display("FAIL mid_update_pulses: got %0d want 0", upd_rises); end
        n_vec++; if (Mode !== 1'b0) begin n_bad++; $display("FAIL mid_mode_after: got %b want 0", Mode); end
    endtask

    initial begin
        init_table();
        m_reset();
        test_reset();
        test_idcode();
        test_ir_capture();
        test_extest();
        test_bypass();
        test_tlr_from_any();
        test_random();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
